tile_config_loader: RTL and testbench
=====================================

Name: tile_config_loader

Overview:
- Writer side of the logic-tile configuration bus: accepts the configuration bitstream as a stream of words over a valid/ready handshake and assembles it in a shadow register.
- Drives the tile's parallel config vector.
- The committed vector updates atomically, only after a complete load, so the tile never sees a partially written configuration.
- Sits between the fabric's config controller and one logic tile's config_in.

Parameters:
- CONFIG_WIDTH, 524, width of the tile config vector (4 LEs x 65 + switchbox 264).
- DATA_WIDTH, 32, width of one bitstream word.
- NUM_WORDS, ceil(CONFIG_WIDTH/DATA_WIDTH) = 17, words per load (derived localparam, not overridable).

Ports:
- clock  input  1  rising-edge clock.
- nreset  input  1  asynchronous active-low reset.
- start  input  1  begin (or restart) a load.
- in_data  input  DATA_WIDTH  bitstream word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a word this cycle.
- config_out  output  CONFIG_WIDTH  committed config; connects to the tile config_in.
- config_done  output  1  one-cycle pulse when config_out is updated.
- busy  output  1  high in LOAD or COMMIT.
- config_error  output  1  sticky parity error (optional feature; tied 0 when the feature is compiled out).

Behaviour:
- Reset (nreset low, async):
  - State IDLE.
  - Word counter 0; shadow register 0; config_out 0.
  - in_ready, config_done, busy and config_error all 0.
- States: IDLE, LOAD, COMMIT (plus ERROR with the optional feature).
- IDLE:
  - in_ready=0, busy=0.
  - start=1 -> LOAD, counter cleared to 0.
- LOAD:
  - in_ready=1, busy=1.
  - A word is accepted when in_valid and in_ready are both high at the clock edge.
  - Word k is written to shadow bits [k*DATA_WIDTH +: DATA_WIDTH]; then counter increments.
  - Last word (k=NUM_WORDS-1): only in_data[CONFIG_WIDTH-1-k*DATA_WIDTH:0] is used (bits [11:0] at defaults); upper bits are ignored.
  - Acceptance of the last word -> COMMIT.
  - start=1 in LOAD -> counter restarts at 0, stays in LOAD, and any word presented that cycle is NOT accepted (in_ready forced 0 that cycle). The shadow is not cleared; later words overwrite it.
- COMMIT (exactly one cycle):
  - in_ready=0, busy=1.
  - config_out <= shadow; config_done=1 for this cycle only.
  - Next state IDLE. start during COMMIT is ignored.
- config_out changes only on the COMMIT edge or on reset. It is held stable through IDLE and LOAD, including during an aborted or restarted load.
- Latency: config_out reflects the new bitstream on the edge after the last word is accepted; config_done is registered and coincident with that update.
- in_valid while in_ready=0: no effect; data is neither consumed nor buffered.
- Reset mid-load: shadow and config_out return to 0; the load is lost.

Optional Feature:
- Macro: CONFIG_PARITY_EN.
- Enabled:
  - Adds input port in_parity (1 bit).
  - Each accepted word must satisfy ^{in_data,in_parity}==0 (even parity over all DATA_WIDTH bits, including ignored bits of the last word).
  - On a mismatch the word is not written and the state goes to ERROR.
  - ERROR: in_ready=0, busy=0, config_error=1, config_out unchanged.
  - start=1 leaves ERROR to LOAD with counter 0 and clears config_error on that edge.
- Disabled: no in_parity port, config_error tied 0, no ERROR state.

Test Plan:
- Reset then start, 17 words 0x00000000..0x00000010 with in_valid held high -> in_ready high for 17 cycles, config_done pulses once on the edge after word 16, config_out[31:0]=0, config_out[63:32]=1, config_out[523:512]=0x010, busy low the following cycle.
- Load all-ones words with in_valid toggling every other cycle -> only valid cycles accepted, 34 cycles to completion, config_out all ones (524 bits); the 20 ignored upper bits of the last word have no effect.
- Complete one load of pattern A, start a load of pattern B, pulse start after 5 words, then send 17 B words -> config_out stays A until the B commit, final config_out = B, single config_done.
- Assert nreset for 1 cycle after 8 words accepted -> config_out=0, in_ready=0, state IDLE; subsequent in_valid words are ignored until start.
- in_valid=1 in IDLE and in COMMIT, start=1 in COMMIT -> no word consumed, config_out unaffected, returns to IDLE.
- (CONFIG_PARITY_EN) Word 3 sent with wrong parity -> config_error=1, in_ready=0, config_out unchanged; start then a clean 17-word load -> config_error clears on the start edge, load commits normally.

Source files
------------

// File: rtl/tile_config_loader.sv
// ============================================================================
// Module   : tile_config_loader
// Brief    : Assembles a word-serial configuration bitstream in a shadow
//            register and commits it atomically to a logic tile's config_in.
//            Optional even-parity checking per word: define CONFIG_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_config_loader #(
    parameter int CONFIG_WIDTH = 524,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
`ifdef CONFIG_PARITY_EN
    input  logic                    in_parity,
`endif
    output logic                    in_ready,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    config_done,
    output logic                    busy,
    output logic                    config_error
);

    localparam int NUM_WORDS   = (CONFIG_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int c_CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int c_LAST_BITS = CONFIG_WIDTH - (NUM_WORDS - 1) * DATA_WIDTH;
    localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(NUM_WORDS - 1);

`ifdef CONFIG_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT, S_ERROR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_t;
`endif

    state_t                  r_state;
    logic [c_CNT_W-1:0]      r_count;
    logic [CONFIG_WIDTH-1:0] r_shadow;
    logic [CONFIG_WIDTH-1:0] r_config;
    logic                    r_ready;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_error;

    logic                    w_accept;
    logic                    w_par_ok;
    logic                    w_write;
    logic [CONFIG_WIDTH-1:0] w_shadow_next;

    // A start in LOAD takes priority over any word presented the same cycle.
    assign w_accept = r_ready & ~start & in_valid;

`ifdef CONFIG_PARITY_EN
    assign w_par_ok = ~(^{in_data, in_parity});
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_write = w_accept & w_par_ok;

    generate
        for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
            localparam logic [c_CNT_W-1:0] c_IDX = c_CNT_W'(k);
            if (k == NUM_WORDS - 1) begin : g_last
                // Only the bits that fit in the vector are kept from the final word.
                assign w_shadow_next[k*DATA_WIDTH +: c_LAST_BITS] =
                    (w_write && (r_count == c_IDX)) ? in_data[c_LAST_BITS-1:0]
                                                    : r_shadow[k*DATA_WIDTH +: c_LAST_BITS];
            end else begin : g_full
                assign w_shadow_next[k*DATA_WIDTH +: DATA_WIDTH] =
                    (w_write && (r_count == c_IDX)) ? in_data
                                                    : r_shadow[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_shadow <= '0;
            r_config <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_shadow <= w_shadow_next;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_LOAD;
                        r_count <= '0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (start) begin
                        r_count <= '0;
                    end else if (w_accept) begin
`ifdef CONFIG_PARITY_EN
                        if (!w_par_ok) begin
                            r_state <= S_ERROR;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b0;
                            r_error <= 1'b1;
                        end else
`endif
                        if (r_count == c_LAST_IDX) begin
                            r_state <= S_COMMIT;
                            r_ready <= 1'b0;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    r_config <= r_shadow;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
`ifdef CONFIG_PARITY_EN
                S_ERROR: begin
                    if (start) begin
                        r_state <= S_LOAD;
                        r_count <= '0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b1;
                        r_error <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_ready & ~start;
    assign config_out  = r_config;
    assign config_done = r_done;
    assign busy        = r_busy;
`ifdef CONFIG_PARITY_EN
    assign config_error = r_error;
`else
    assign config_error = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tile_config_loader.sv
// ============================================================================
// Module   : tb_tile_config_loader
// Brief    : Self-checking bench for tile_config_loader against a word-array
//            model of the shadow/committed configuration.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tile_config_loader;

    localparam int CW = 524;
    localparam int DW = 32;
    localparam int NW = 17;

    logic          clock = 1'b0;
    logic          nreset;
    logic          start;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_parity;
    logic          in_ready;
    logic [CW-1:0] config_out;
    logic          config_done;
    logic          busy;
    logic          config_error;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] words [NW];
    logic [DW-1:0] sh    [NW];
    logic [CW-1:0] committed;
    logic [CW-1:0] pat_a;
    int            cyc;
    logic          hit_err;

    tile_config_loader dut (
        .clock       (clock),
        .nreset      (nreset),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
`ifdef CONFIG_PARITY_EN
        .in_parity   (in_parity),
`endif
        .in_ready    (in_ready),
        .config_out  (config_out),
        .config_done (config_done),
        .busy        (busy),
        .config_error(config_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // The committed vector is simply the words laid end to end, truncated.
    function automatic logic [CW-1:0] compose();
        logic [NW*DW-1:0] t;
        t = '0;
        for (int k = 0; k < NW; k++) t[k*DW +: DW] = sh[k];
        return t[CW-1:0];
    endfunction

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", CW'(busy), CW'(1));
    endtask

    // mode 0: valid held, 1: valid every other cycle, 2: random valid
    task automatic load_body(input int mode, input int n, input int bad_idx,
                             output int ncyc, output logic err);
        int k;
        logic v;
        k    = 0;
        ncyc = 0;
        err  = 1'b0;
        while (k < n && ncyc < 300) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = ncyc[0];
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            in_data  = words[k];
            in_parity = (k == bad_idx) ? ~(^words[k]) : ^words[k];
            #1;
            chk("ready_in_load", CW'(in_ready), CW'(1));
            chk("no_done_in_load", CW'(config_done), CW'(0));
            @(posedge clock);
            #1;
            if (v) begin
                if (k == bad_idx) begin
                    err = 1'b1;
                    k   = n;
                end else begin
                    sh[k] = words[k];
                    k++;
                end
            end
            ncyc++;
        end
        in_valid = 1'b0;
        if (ncyc >= 300) chk("load_timeout", CW'(ncyc), CW'(0));
    endtask

    task automatic commit_check();
        logic [CW-1:0] nv;
        nv = compose();
        chk("commit_busy", CW'(busy), CW'(1));
        chk("commit_ready", CW'(in_ready), CW'(0));
        chk("commit_no_done_yet", CW'(config_done), CW'(0));
        chk("commit_cfg_held", config_out, committed);
        in_valid = 1'b1;
        start    = 1'b1;
        in_data  = $urandom;
        #1;
        chk("commit_ready_w_start", CW'(in_ready), CW'(0));
        tick();
        start = 1'b0;
        chk("done_pulse", CW'(config_done), CW'(1));
        chk("cfg_updated", config_out, nv);
        chk("busy_after_commit", CW'(busy), CW'(0));
        #1;
        chk("idle_ready", CW'(in_ready), CW'(0));
        tick();
        chk("done_single", CW'(config_done), CW'(0));
        chk("idle_busy", CW'(busy), CW'(0));
        chk("cfg_stable_idle", config_out, nv);
        in_valid  = 1'b0;
        committed = nv;
    endtask

    initial begin
        nreset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_parity = 1'b0;
        committed = '0;
        for (int k = 0; k < NW; k++) sh[k] = '0;
        tick(); tick();
        chk("rst_cfg", config_out, '0);
        chk("rst_ready", CW'(in_ready), CW'(0));
        chk("rst_done", CW'(config_done), CW'(0));
        chk("rst_busy", CW'(busy), CW'(0));
        chk("rst_error", CW'(config_error), CW'(0));
        nreset = 1'b1;
        tick();

        // valid while idle is ignored
        in_valid = 1'b1; in_data = 32'hDEADBEEF;
        tick();
        chk("idle_ignore_ready", CW'(in_ready), CW'(0));
        chk("idle_ignore_busy", CW'(busy), CW'(0));
        in_valid = 1'b0;

        // counting words, valid held high
        for (int k = 0; k < NW; k++) words[k] = DW'(k);
        do_start();
        load_body(0, NW, -1, cyc, hit_err);
        chk("count_cycles", CW'(cyc), CW'(17));
        commit_check();
        chk("cnt_w0", CW'(config_out[31:0]), CW'(0));
        chk("cnt_w1", CW'(config_out[63:32]), CW'(1));
        chk("cnt_last", CW'(config_out[523:512]), CW'(12'h010));

        // all ones, valid toggling
        for (int k = 0; k < NW; k++) words[k] = '1;
        do_start();
        load_body(1, NW, -1, cyc, hit_err);
        chk("toggle_cycles", CW'(cyc), CW'(34));
        commit_check();
        chk("all_ones", config_out, {CW{1'b1}});

        // pattern A, then an aborted/restarted pattern B
        for (int k = 0; k < NW; k++) words[k] = $urandom;
        do_start();
        load_body(2, NW, -1, cyc, hit_err);
        commit_check();
        pat_a = committed;
        for (int k = 0; k < NW; k++) words[k] = $urandom;
        do_start();
        load_body(0, 5, -1, cyc, hit_err);
        chk("partial_holds_a", config_out, pat_a);
        start = 1'b1; in_valid = 1'b1; in_data = $urandom;
        #1;
        chk("restart_blocks_ready", CW'(in_ready), CW'(0));
        tick();
        start = 1'b0; in_valid = 1'b0;
        chk("restart_holds_a", config_out, pat_a);
        chk("restart_busy", CW'(busy), CW'(1));
        load_body(2, NW, -1, cyc, hit_err);
        chk("b_load_holds_a", config_out, pat_a);
        commit_check();

        // reset in the middle of a load
        for (int k = 0; k < NW; k++) words[k] = $urandom;
        do_start();
        load_body(0, 8, -1, cyc, hit_err);
        nreset = 1'b0;
        #1;
        chk("midrst_cfg", config_out, '0);
        chk("midrst_ready", CW'(in_ready), CW'(0));
        chk("midrst_busy", CW'(busy), CW'(0));
        tick();
        nreset = 1'b1;
        committed = '0;
        for (int k = 0; k < NW; k++) sh[k] = '0;
        in_valid = 1'b1; in_data = $urandom;
        tick(); tick();
        chk("postrst_ready", CW'(in_ready), CW'(0));
        chk("postrst_busy", CW'(busy), CW'(0));
        chk("postrst_cfg", config_out, '0);
        in_valid = 1'b0;
        for (int k = 0; k < NW; k++) words[k] = $urandom;
        do_start();
        load_body(2, NW, -1, cyc, hit_err);
        commit_check();

`ifdef CONFIG_PARITY_EN
        for (int k = 0; k < NW; k++) words[k] = $urandom;
        do_start();
        load_body(0, NW, 3, cyc, hit_err);
        chk("par_err_seen", CW'(hit_err), CW'(1));
        chk("par_error_flag", CW'(config_error), CW'(1));
        chk("par_ready", CW'(in_ready), CW'(0));
        chk("par_busy", CW'(busy), CW'(0));
        chk("par_cfg_held", config_out, committed);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("par_err_sticky", CW'(config_error), CW'(1));
        do_start();
        chk("par_err_cleared", CW'(config_error), CW'(0));
        for (int k = 0; k < NW; k++) words[k] = $urandom;
        load_body(2, NW, -1, cyc, hit_err);
        commit_check();
        chk("par_no_error", CW'(config_error), CW'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
